// File: rtl/cdb_if.sv
// Common data bus arbiter interface: producer handshakes, flush, broadcast bus
// and FIFO occupancy. The master side drives results in; the slave is the arbiter.
interface cdb_if #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 3,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              flush;
    logic              alu_valid;
    logic              alu_ready;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [TAG_W-1:0]  mem_tag;
    logic [DATA_W-1:0] mem_data;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [CNT_W-1:0]  alu_count;
    logic [CNT_W-1:0]  mem_count;

    modport master (
        output flush, alu_valid, alu_tag, alu_data, mem_valid, mem_tag, mem_data,
        input  alu_ready, mem_ready, cdb_valid, cdb_tag, cdb_data, alu_count, mem_count
    );

    modport slave (
        input  flush, alu_valid, alu_tag, alu_data, mem_valid, mem_tag, mem_data,
        output alu_ready, mem_ready, cdb_valid, cdb_tag, cdb_data, alu_count, mem_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: two small result FIFOs (ALU = source 0, MEM = source 1) feeding
// one registered broadcast per cycle. Tag 0 means "no result" and is never stored.
// Build option CDB_RR_ARB_EN: round-robin on contention; otherwise MEM has fixed
// priority and ALU is only granted when the MEM FIFO is empty.
module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    cdb_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NSRC  = 2;

    logic [NSRC-1:0]                              w_valid, w_ready, w_push, w_ne, w_grant;
    logic [NSRC-1:0][TAG_W-1:0]                   w_in_tag, w_head_tag;
    logic [NSRC-1:0][DATA_W-1:0]                  w_in_data, w_head_data;
    logic [TAG_W-1:0]                             w_sel_tag;
    logic [DATA_W-1:0]                            w_sel_data;

    logic [NSRC-1:0][FIFO_DEPTH-1:0][TAG_W-1:0]   r_tag;
    logic [NSRC-1:0][FIFO_DEPTH-1:0][DATA_W-1:0]  r_data;
    logic [NSRC-1:0][PTR_W-1:0]                   r_wp, r_rp;
    logic [NSRC-1:0][CNT_W-1:0]                   r_cnt;
    logic                                         r_cdb_valid;
    logic [TAG_W-1:0]                             r_cdb_tag;
    logic [DATA_W-1:0]                            r_cdb_data;

    assign w_valid   = {bus.mem_valid, bus.alu_valid};
    assign w_in_tag  = {bus.mem_tag,   bus.alu_tag};
    assign w_in_data = {bus.mem_data,  bus.alu_data};

    // Per-source push qualification and head-of-queue view
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            w_ready[s]     = (r_cnt[s] != CNT_W'(FIFO_DEPTH));
            w_ne[s]        = (r_cnt[s] != '0);
            w_push[s]      = w_valid[s] && w_ready[s] && (w_in_tag[s] != '0);
            w_head_tag[s]  = r_tag[s][r_rp[s]];
            w_head_data[s] = r_data[s][r_rp[s]];
        end
    end

`ifdef CDB_RR_ARB_EN
    // Favoured source on contention: 0 = ALU, 1 = MEM
    logic r_rr;

    // Round-robin pick: contention follows the pointer, otherwise the lone non-empty source
    always_comb begin
        w_grant = '0;
        if (w_ne[0] && w_ne[1]) w_grant[r_rr] = 1'b1;
        else if (w_ne[1])       w_grant[1]    = 1'b1;
        else if (w_ne[0])       w_grant[0]    = 1'b1;
    end

    // Pointer flips to the other source after any grant; flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_rr <= 1'b0;
        else if (!bus.flush && |w_grant) r_rr <= w_grant[0];
    end
`else
    // Fixed priority: MEM wins whenever it has something queued
    always_comb begin
        w_grant = '0;
        if (w_ne[1])      w_grant[1] = 1'b1;
        else if (w_ne[0]) w_grant[0] = 1'b1;
    end
`endif

    // Winner's head goes onto the bus; zero when nothing is granted
    always_comb begin
        w_sel_tag  = '0;
        w_sel_data = '0;
        if (w_grant[1]) begin
            w_sel_tag  = w_head_tag[1];
            w_sel_data = w_head_data[1];
        end else if (w_grant[0]) begin
            w_sel_tag  = w_head_tag[0];
            w_sel_data = w_head_data[0];
        end
    end

    // FIFO pointers and occupancy; flush empties both queues outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (bus.flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (w_push[s])  r_wp[s] <= r_wp[s] + PTR_W'(1);
                if (w_grant[s]) r_rp[s] <= r_rp[s] + PTR_W'(1);
                r_cnt[s] <= r_cnt[s] + CNT_W'(w_push[s]) - CNT_W'(w_grant[s]);
            end
        end
    end

    // Entry storage; contents are don't-care while unoccupied so no reset
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (w_push[s] && !bus.flush) begin
                r_tag[s][r_wp[s]]  <= w_in_tag[s];
                r_data[s][r_wp[s]] <= w_in_data[s];
            end
        end
    end

    // Registered broadcast, one cycle per grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else if (bus.flush) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else begin
            r_cdb_valid <= |w_grant;
            r_cdb_tag   <= w_sel_tag;
            r_cdb_data  <= w_sel_data;
        end
    end

    assign bus.alu_ready = w_ready[0];
    assign bus.mem_ready = w_ready[1];
    assign bus.alu_count = r_cnt[0];
    assign bus.mem_count = r_cnt[1];
    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_data;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for uncontended traffic, then
// hand sequences for contention, starvation, flush and async reset.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cdb_if #(.DATA_W(32), .TAG_W(3), .FIFO_DEPTH(2)) bus ();

    cdb_arbiter #(.DATA_W(32), .TAG_W(3), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        fl;
        logic        av;
        logic [2:0]  at;
        logic [31:0] ad;
        logic        mv;
        logic [2:0]  mt;
        logic [31:0] md;
        logic        e_v;
        logic [2:0]  e_t;
        logic [31:0] e_d;
        logic [1:0]  e_ac;
        logic [1:0]  e_mc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic av, input logic [2:0] at, input logic [31:0] ad,
                         input logic mv, input logic [2:0] mt, input logic [31:0] md);
        bus.flush     = fl;
        bus.alu_valid = av;
        bus.alu_tag   = at;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_tag   = mt;
        bus.mem_data  = md;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_cdb(input string name, input logic v, input logic [2:0] t, input logic [31:0] d);
        chk({name, ".valid"}, 64'(bus.cdb_valid), 64'(v));
        chk({name, ".tag"},   64'(bus.cdb_tag),   64'(t));
        chk({name, ".data"},  64'(bus.cdb_data),  64'(d));
    endtask

    function automatic logic [2:0] mtag(input int k);
        return 3'(4 + (k % 4));
    endfunction

    initial begin
        // row: fl av at ad mv mt md | valid tag data acnt mcnt
        vecs[0]  = '{0,0,0,0,           0,0,0,          0,0,0,           0,0};
        vecs[1]  = '{0,1,3,32'h11,      0,0,0,          0,0,0,           1,0};
        vecs[2]  = '{0,0,0,0,           0,0,0,          1,3,32'h11,      0,0};
        vecs[3]  = '{0,0,0,0,           0,0,0,          0,0,0,           0,0};
        vecs[4]  = '{0,1,0,32'h55,      0,0,0,          0,0,0,           0,0};
        vecs[5]  = '{0,0,0,0,           0,0,0,          0,0,0,           0,0};
        vecs[6]  = '{0,0,0,0,           1,4,32'h44,     0,0,0,           0,1};
        vecs[7]  = '{0,0,0,0,           1,5,32'h45,     1,4,32'h44,      0,1};
        vecs[8]  = '{0,0,0,0,           0,0,0,          1,5,32'h45,      0,0};
        vecs[9]  = '{0,0,0,0,           0,0,0,          0,0,0,           0,0};
        vecs[10] = '{0,1,1,32'hA1,      0,0,0,          0,0,0,           1,0};
        vecs[11] = '{0,1,2,32'hA2,      0,0,0,          1,1,32'hA1,      1,0};
        vecs[12] = '{0,1,3,32'hA3,      0,0,0,          1,2,32'hA2,      1,0};
        vecs[13] = '{0,0,0,0,           0,0,0,          1,3,32'hA3,      0,0};
        vecs[14] = '{0,0,0,0,           0,0,0,          0,0,0,           0,0};

        idle();
        #2;
        chk_cdb("reset", 1'b0, 3'd0, 32'd0);
        chk("reset.acnt", 64'(bus.alu_count), 64'd0);
        chk("reset.mcnt", 64'(bus.mem_count), 64'd0);
        do_reset();
        #1;
        chk("reset.aready", 64'(bus.alu_ready), 64'd1);
        chk("reset.mready", 64'(bus.mem_ready), 64'd1);

        // Uncontended traffic from the table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fl, vecs[i].av, vecs[i].at, vecs[i].ad, vecs[i].mv, vecs[i].mt, vecs[i].md);
            step();
            chk_cdb($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_t, vecs[i].e_d);
            chk($sformatf("vec%0d.acnt", i), 64'(bus.alu_count), 64'(vecs[i].e_ac));
            chk($sformatf("vec%0d.mcnt", i), 64'(bus.mem_count), 64'(vecs[i].e_mc));
            chk($sformatf("vec%0d.aready", i), 64'(bus.alu_ready), 64'd1);
            idle();
        end

        // Same-edge push on both sources
        do_reset();
        drive(1'b0, 1'b1, 3'd1, 32'hA, 1'b1, 3'd2, 32'hB);
        step();
        idle();
        chk("contend.acnt", 64'(bus.alu_count), 64'd1);
        chk("contend.mcnt", 64'(bus.mem_count), 64'd1);
        step();
`ifdef CDB_RR_ARB_EN
        chk_cdb("contend.first", 1'b1, 3'd1, 32'hA);
        step();
        chk_cdb("contend.second", 1'b1, 3'd2, 32'hB);
`else
        chk_cdb("contend.first", 1'b1, 3'd2, 32'hB);
        step();
        chk_cdb("contend.second", 1'b1, 3'd1, 32'hA);
`endif
        step();
        chk_cdb("contend.idle", 1'b0, 3'd0, 32'd0);

`ifndef CDB_RR_ARB_EN
        // MEM streams every cycle; ALU fills up and starves
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b1, (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : 3'd3, 32'hA0 + 32'(k),
                  1'b1, mtag(k), 32'h100 * k);
            step();
            if (k >= 2) begin
                chk_cdb($sformatf("starve%0d", k), 1'b1, mtag(k - 1), 32'h100 * (k - 1));
                chk($sformatf("starve%0d.aready", k), 64'(bus.alu_ready), 64'd0);
            end
            chk($sformatf("starve%0d.acnt", k), 64'(bus.alu_count), (k == 1) ? 64'd1 : 64'd2);
        end
        idle();
        step();
        chk_cdb("drain.mem", 1'b1, mtag(6), 32'h600);
        chk("drain.mcnt", 64'(bus.mem_count), 64'd0);
        step();
        chk_cdb("drain.alu1", 1'b1, 3'd1, 32'hA1);
        chk("drain.acnt1", 64'(bus.alu_count), 64'd1);
        step();
        chk_cdb("drain.alu2", 1'b1, 3'd2, 32'hA2);
        chk("drain.acnt0", 64'(bus.alu_count), 64'd0);
        step();
        chk_cdb("drain.idle", 1'b0, 3'd0, 32'd0);
`endif

        // Fill as far as one-pop-per-cycle allows, then flush with offers present
        do_reset();
        drive(1'b0, 1'b1, 3'd1, 32'h1, 1'b1, 3'd2, 32'h2);
        step();
        drive(1'b0, 1'b1, 3'd3, 32'h3, 1'b1, 3'd4, 32'h4);
        step();
        chk("fill.total", 64'(bus.alu_count) + 64'(bus.mem_count), 64'd3);
        chk("fill.onefull", 64'(bus.alu_ready & bus.mem_ready), 64'd0);
        drive(1'b1, 1'b1, 3'd5, 32'h5, 1'b1, 3'd6, 32'h6);
        step();
        idle();
        chk_cdb("flush", 1'b0, 3'd0, 32'd0);
        chk("flush.acnt", 64'(bus.alu_count), 64'd0);
        chk("flush.mcnt", 64'(bus.mem_count), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("flush.quiet%0d", k), 64'(bus.cdb_valid), 64'd0);
        end
        drive(1'b0, 1'b1, 3'd7, 32'h77, 1'b0, 3'd0, 32'd0);
        step();
        idle();
        chk("postflush.acnt", 64'(bus.alu_count), 64'd1);
        step();
        chk_cdb("postflush", 1'b1, 3'd7, 32'h77);

        // Async reset in the middle of a broadcast
        do_reset();
        drive(1'b0, 1'b1, 3'd5, 32'h55, 1'b0, 3'd0, 32'd0);
        step();
        drive(1'b0, 1'b1, 3'd6, 32'h66, 1'b0, 3'd0, 32'd0);
        step();
        idle();
        chk_cdb("prerst", 1'b1, 3'd5, 32'h55);
        chk("prerst.acnt", 64'(bus.alu_count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cdb("asyncrst", 1'b0, 3'd0, 32'd0);
        chk("asyncrst.acnt", 64'(bus.alu_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 3'd2, 32'h22, 1'b0, 3'd0, 32'd0);
        step();
        idle();
        chk_cdb("resume.idle", 1'b0, 3'd0, 32'd0);
        step();
        chk_cdb("resume", 1'b1, 3'd2, 32'h22);
        step();
        chk_cdb("resume.end", 1'b0, 3'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
